// File: rtl/disp_mux.sv
// disp_mux: snapshots the BCD time digits once per scan frame and
// multiplexes them onto a 6-digit common-anode 7-segment display.
module disp_mux #(
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned BLINK_TICKS = 250,
    parameter bit          LZB         = 1'b0
) (
    input  logic       disp_clock,
    input  logic       disp_reset,
    input  logic       disp_enable,
    input  logic [1:0] disp_h_msd,
    input  logic [3:0] disp_h_lsd,
    input  logic [2:0] disp_m_msd,
    input  logic [3:0] disp_m_lsd,
    input  logic [2:0] disp_s_msd,
    input  logic [3:0] disp_s_lsd,
    input  logic [1:0] disp_blink_sel,
    output logic [5:0] disp_an,
    output logic [6:0] disp_seg,
    output logic       disp_dp
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);
    localparam logic [BW-1:0] BLINK_ONE = BW'(1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [PW-1:0]     presc_q, presc_d;
    logic [2:0]        idx_q, idx_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic              phase_q, phase_d;
    logic [5:0][3:0]   snap_q, snap_d;
    logic [5:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;

    logic              tick;
    logic [3:0]        digit;
    logic [1:0]        pair_sel;
    logic              blank;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // Scan timing, blink timing and frame-coherent snapshot
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        snap_d  = snap_q;
        tick    = disp_enable && (presc_q == PRESC_MAX);
        if (disp_enable) begin
            presc_d = tick ? '0 : presc_q + PRESC_ONE;
        end
        if (tick) begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
            if (bcnt_q == BLINK_MAX) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + BLINK_ONE;
            end
            if (idx_q == 3'd5) begin
                snap_d = {{2'b00, disp_h_msd}, disp_h_lsd,
                          {1'b0, disp_m_msd}, disp_m_lsd,
                          {1'b0, disp_s_msd}, disp_s_lsd};
            end
        end
    end

    always_comb begin
        case (idx_q)
            3'd1:    digit = snap_q[1];
            3'd2:    digit = snap_q[2];
            3'd3:    digit = snap_q[3];
            3'd4:    digit = snap_q[4];
            3'd5:    digit = snap_q[5];
            default: digit = snap_q[0];
        endcase
    end

    // Pairs are idx {0,1}, {2,3}, {4,5}; blink_sel 11/10/01 picks them
    always_comb begin
        pair_sel = 2'd3 - disp_blink_sel;
        blank    = (disp_blink_sel != 2'b00) && phase_q
                   && (idx_q[2:1] == pair_sel);
        if (LZB && (idx_q == 3'd5) && (snap_q[5] == 4'd0)) begin
            blank = 1'b1;
        end
    end

    always_comb begin
        an_d  = 6'b111111;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (disp_enable) begin
            an_d  = ~(6'b000001 << idx_q);
            seg_d = blank ? SEG_BLANK : seg7(digit);
            dp_d  = !((idx_q == 3'd2) || (idx_q == 3'd4));
        end
    end

    always_ff @(posedge disp_clock or negedge disp_reset) begin
        if (!disp_reset) begin
            presc_q <= '0;
            idx_q   <= 3'd0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            snap_q  <= '0;
            an_q    <= 6'b111111;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign disp_an  = an_q;
    assign disp_seg = seg_q;
    assign disp_dp  = dp_q;

endmodule
